// File: rtl/led_flow_pwm_driver_if.sv
// Control and LED-output bundle between the mode-select mux (master) and one
// flow-driver slot (slave).
interface led_flow_pwm_driver_if #(
   parameter int N_LED = 8,
   parameter int POS_W = $clog2(N_LED)
);
   logic             en;
   logic             dir;
   logic [1:0]       mode;
   logic [N_LED-1:0] led_out;
   logic [POS_W-1:0] head_pos;
   logic             step_pulse;

   modport master (output en, dir, mode, input led_out, head_pos, step_pulse);
   modport slave  (input en, dir, mode, output led_out, head_pos, step_pulse);
endinterface

// File: rtl/led_flow_pwm_driver.sv
// Water-flow LED driver: a PEAK-duty head steps across N_LED channels while every
// channel it leaves fades out; each channel is driven by a shared-counter PWM.
module led_flow_pwm_driver #(
   parameter int N_LED        = 8,
   parameter int PWM_BITS     = 8,
   parameter int STEP_CYCLES  = 2400,
   parameter int DECAY_CYCLES = 40,
   parameter int DECAY_STEP   = 16,
   parameter int PEAK         = (1 << PWM_BITS) - 1,
   parameter int POS_W        = $clog2(N_LED)
) (
   input logic                  clk,
   input logic                  rst,
   led_flow_pwm_driver_if.slave bus
);
   localparam int STEP_W = $clog2(STEP_CYCLES);
   localparam int DEC_W  = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;

   localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_CYCLES - 1);
   localparam logic [DEC_W-1:0]    DEC_LAST  = DEC_W'(DECAY_CYCLES - 1);
   localparam logic [POS_W-1:0]    POS_LAST  = POS_W'(N_LED - 1);
   localparam logic [PWM_BITS-1:0] PEAK_DUTY = PWM_BITS'(PEAK);
   localparam logic [PWM_BITS-1:0] FADE_STEP = PWM_BITS'(DECAY_STEP);

   typedef enum logic [1:0] {
      MODE_WRAP   = 2'b00,
      MODE_BOUNCE = 2'b01,
      MODE_HOLD   = 2'b10,
      MODE_OFF    = 2'b11
   } mode_e;

   mode_e               mode;
   logic                stepTick;
   logic                decayTick;

   logic [STEP_W-1:0]   stepCnt_q, stepCnt_d;
   logic [DEC_W-1:0]    decayCnt_q, decayCnt_d;
   logic [PWM_BITS-1:0] pwmCnt_q, pwmCnt_d;
   logic [POS_W-1:0]    pos_q, pos_d;
   logic                bounceDown_q, bounceDown_d;
   logic [PWM_BITS-1:0] duty_q [N_LED];
   logic [PWM_BITS-1:0] duty_d [N_LED];
   logic [N_LED-1:0]    ledOut_q, ledOut_d;
   logic                stepPulse_q;

   assign mode      = mode_e'(bus.mode);
   assign stepTick  = bus.en && (stepCnt_q == STEP_LAST);
   assign decayTick = bus.en && (decayCnt_q == DEC_LAST);
   assign pwmCnt_d  = pwmCnt_q + PWM_BITS'(1);

   // Both prescalers freeze with en low and resume where they stopped.
   always_comb begin
      stepCnt_d  = stepCnt_q;
      decayCnt_d = decayCnt_q;
      if (bus.en) begin
         stepCnt_d  = stepTick  ? '0 : stepCnt_q + STEP_W'(1);
         decayCnt_d = decayTick ? '0 : decayCnt_q + DEC_W'(1);
      end
   end

   // Bounce direction shadows dir until bounce mode takes ownership of it.
   always_comb begin
      pos_d        = pos_q;
      bounceDown_d = (mode == MODE_BOUNCE) ? bounceDown_q : bus.dir;
      if (stepTick) begin
         case (mode)
            MODE_WRAP: begin
               if (bus.dir) begin
                  pos_d = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
               end else begin
                  pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
               end
            end
            MODE_BOUNCE: begin
               if (!bounceDown_q) begin
                  if (pos_q == POS_LAST) begin
                     pos_d        = POS_LAST - POS_W'(1);
                     bounceDown_d = 1'b1;
                  end else begin
                     pos_d = pos_q + POS_W'(1);
                  end
               end else begin
                  if (pos_q == '0) begin
                     pos_d        = POS_W'(1);
                     bounceDown_d = 1'b0;
                  end else begin
                     pos_d = pos_q - POS_W'(1);
                  end
               end
            end
            default: pos_d = pos_q;
         endcase
      end
   end

   // Off beats everything; the freshly loaded head beats a coincident fade.
   always_comb begin
      for (int i = 0; i < N_LED; i++) begin
         duty_d[i] = duty_q[i];
         if (decayTick) begin
            duty_d[i] = (duty_q[i] > FADE_STEP) ? duty_q[i] - FADE_STEP : '0;
         end
         if (stepTick && (pos_d == POS_W'(i))) begin
            duty_d[i] = PEAK_DUTY;
         end
         if (mode == MODE_OFF) begin
            duty_d[i] = '0;
         end
      end
   end

   always_comb begin
      ledOut_d = '0;
      for (int i = 0; i < N_LED; i++) begin
         ledOut_d[i] = (pwmCnt_q < duty_q[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stepCnt_q    <= '0;
         decayCnt_q   <= '0;
         pwmCnt_q     <= '0;
         pos_q        <= '0;
         bounceDown_q <= 1'b0;
         ledOut_q     <= '0;
         stepPulse_q  <= 1'b0;
         for (int i = 0; i < N_LED; i++) begin
            duty_q[i] <= '0;
         end
      end else begin
         stepCnt_q    <= stepCnt_d;
         decayCnt_q   <= decayCnt_d;
         pwmCnt_q     <= pwmCnt_d;
         pos_q        <= pos_d;
         bounceDown_q <= bounceDown_d;
         ledOut_q     <= ledOut_d;
         stepPulse_q  <= stepTick;
         for (int i = 0; i < N_LED; i++) begin
            duty_q[i] <= duty_d[i];
         end
      end
   end

   assign bus.led_out    = ledOut_q;
   assign bus.head_pos   = pos_q;
   assign bus.step_pulse = stepPulse_q;
endmodule

// File: tb/tb_led_flow_pwm_driver.sv
// Bench for led_flow_pwm_driver: directed head/fade/reset scenarios plus random
// en/dir/mode traffic, all compared each cycle against an arithmetic reference.
module tb_led_flow_pwm_driver;
   localparam int N_LED        = 4;
   localparam int PWM_BITS     = 8;
   localparam int STEP_CYCLES  = 8;
   localparam int DECAY_CYCLES = 2;
   localparam int DECAY_STEP   = 50;
   localparam int PEAK         = 200;
   localparam int PERIOD       = 1 << PWM_BITS;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checkCount = 0;
   int passCount  = 0;

   // Reference model state: counts of cycles since reset rather than counters.
   int mCycle;
   int mEnCycles;
   int mPos;
   bit mDown;
   int mDuty [N_LED];
   int mLed;
   bit mPulse;

   led_flow_pwm_driver_if #(.N_LED(N_LED)) bus ();

   led_flow_pwm_driver #(
      .N_LED(N_LED),
      .PWM_BITS(PWM_BITS),
      .STEP_CYCLES(STEP_CYCLES),
      .DECAY_CYCLES(DECAY_CYCLES),
      .DECAY_STEP(DECAY_STEP),
      .PEAK(PEAK)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed == expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      mCycle    = 0;
      mEnCycles = 0;
      mPos      = 0;
      mDown     = 1'b0;
      mLed      = 0;
      mPulse    = 1'b0;
      for (int i = 0; i < N_LED; i++) mDuty[i] = 0;
   endtask

   // Predicts the registered outputs after the next rising edge.
   task automatic modelAdvance(input bit e, input bit d, input int m);
      bit stepTick;
      bit decayTick;
      int newLed;
      stepTick  = e && ((mEnCycles % STEP_CYCLES) == STEP_CYCLES - 1);
      decayTick = e && ((mEnCycles % DECAY_CYCLES) == DECAY_CYCLES - 1);
      newLed = 0;
      for (int i = 0; i < N_LED; i++) begin
         if ((mCycle % PERIOD) < mDuty[i]) newLed |= (1 << i);
      end
      if (stepTick && m == 0) begin
         mPos = d ? (mPos + N_LED - 1) % N_LED : (mPos + 1) % N_LED;
      end else if (stepTick && m == 1) begin
         if (!mDown && mPos == N_LED - 1) begin
            mPos  = N_LED - 2;
            mDown = 1'b1;
         end else if (mDown && mPos == 0) begin
            mPos  = 1;
            mDown = 1'b0;
         end else begin
            mPos = mDown ? mPos - 1 : mPos + 1;
         end
      end
      if (m != 1) mDown = d;
      for (int i = 0; i < N_LED; i++) begin
         if (m == 3) mDuty[i] = 0;
         else if (stepTick && i == mPos) mDuty[i] = PEAK;
         else if (decayTick) mDuty[i] = (mDuty[i] > DECAY_STEP) ? mDuty[i] - DECAY_STEP : 0;
      end
      mLed   = newLed;
      mPulse = stepTick;
      mCycle++;
      if (e) mEnCycles++;
   endtask

   // Called at a falling edge: drive inputs, run one clock, compare outputs.
   task automatic applyStimulus(input bit e, input bit d, input int m);
      bus.en   = e;
      bus.dir  = d;
      bus.mode = 2'(m);
      modelAdvance(e, d, m);
      @(posedge clk);
      @(negedge clk);
      checkOutput("led_out", int'(bus.led_out), mLed);
      checkOutput("head_pos", int'(bus.head_pos), mPos);
      checkOutput("step_pulse", int'(bus.step_pulse), int'(mPulse));
   endtask

   task automatic doReset(input int holdCycles);
      rst = 1'b1;
      modelReset();
      #1;
      checkOutput("rst_led_out", int'(bus.led_out), 0);
      checkOutput("rst_head_pos", int'(bus.head_pos), 0);
      checkOutput("rst_step_pulse", int'(bus.step_pulse), 0);
      @(negedge clk);
      repeat (holdCycles - 1) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic runHeadSequence(input string tag, input bit d, input int m,
                                  input int expSeq[8], input int len);
      int gap;
      for (int k = 0; k < len; k++) begin
         gap = 0;
         do begin
            applyStimulus(1'b1, d, m);
            gap++;
         end while (bus.step_pulse !== 1'b1 && gap < 4 * STEP_CYCLES);
         checkOutput($sformatf("%s_gap%0d", tag, k), gap, STEP_CYCLES);
         checkOutput($sformatf("%s_head%0d", tag, k), int'(bus.head_pos), expSeq[k]);
      end
   endtask

   // With en low the duties are frozen, so one full PWM period of high cycles equals the duty.
   task automatic measureDuty(input string tag, input int expDuty[N_LED]);
      int highs [N_LED];
      for (int i = 0; i < N_LED; i++) highs[i] = 0;
      for (int c = 0; c < PERIOD; c++) begin
         applyStimulus(1'b0, 1'b0, 0);
         for (int i = 0; i < N_LED; i++) if (bus.led_out[i]) highs[i]++;
      end
      for (int i = 0; i < N_LED; i++) begin
         checkOutput($sformatf("%s_ch%0d", tag, i), highs[i], expDuty[i]);
      end
   endtask

   initial begin
      int wrapUp[8]   = '{1, 2, 3, 0, 1, 0, 0, 0};
      int wrapDown[8] = '{3, 2, 1, 0, 3, 0, 0, 0};
      int bounce[8]   = '{1, 2, 3, 2, 1, 0, 1, 0};
      int fadeExp[6][N_LED] = '{'{0, 200, 0, 0}, '{0, 150, 0, 0}, '{0, 100, 0, 0},
                                '{0, 50, 0, 0},  '{0, 0, 200, 0}, '{0, 0, 150, 0}};
      int zeros[N_LED] = '{0, 0, 0, 0};
      int pulses;
      int frozenHead;
      bit rEn;
      bit rDir;
      int rMode;

      bus.en   = 1'b0;
      bus.dir  = 1'b0;
      bus.mode = 2'b00;
      modelReset();
      @(negedge clk);
      doReset(3);

      $display("[TB] wrap up");
      runHeadSequence("wrapUp", 1'b0, 0, wrapUp, 5);
      doReset(2);
      $display("[TB] wrap down");
      runHeadSequence("wrapDown", 1'b1, 0, wrapDown, 5);
      doReset(2);
      $display("[TB] bounce");
      runHeadSequence("bounce", 1'b0, 1, bounce, 7);

      $display("[TB] fade");
      doReset(2);
      repeat (STEP_CYCLES) applyStimulus(1'b1, 1'b0, 0);
      for (int k = 0; k < 6; k++) begin
         if (k > 0) repeat (2) applyStimulus(1'b1, 1'b0, 0);
         measureDuty($sformatf("fade%0d", k), fadeExp[k]);
      end

      $display("[TB] freeze then off");
      pulses     = 0;
      frozenHead = int'(bus.head_pos);
      repeat (100) begin
         applyStimulus(1'b0, 1'b0, 0);
         if (bus.step_pulse) pulses++;
      end
      checkOutput("freezePulses", pulses, 0);
      checkOutput("freezeHead", int'(bus.head_pos), 2);
      checkOutput("freezeHeadStable", int'(bus.head_pos), frozenHead);
      repeat (2) applyStimulus(1'b0, 1'b0, 3);
      checkOutput("offLedWithin2", int'(bus.led_out), 0);
      repeat (10) begin
         applyStimulus(1'b1, 1'b0, 3);
         checkOutput("offLedStays", int'(bus.led_out), 0);
      end

      $display("[TB] mid-run reset");
      repeat (20) applyStimulus(1'b1, 1'b0, 0);
      doReset(5);
      measureDuty("postRst", zeros);

      $display("[TB] random traffic");
      rDir  = 1'b0;
      rMode = 0;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 39) == 0) rMode = int'($urandom_range(0, 3));
         if ($urandom_range(0, 29) == 0) rDir = ~rDir;
         rEn = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 599) == 0) doReset(2);
         applyStimulus(rEn, rDir, rMode);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
